streaming_deskewer: RTL and testbench
=====================================

Name: streaming_deskewer

Overview:
- Output-side counterpart of the input skewer. It takes the diagonally skewed result stream leaving the bottom/right edge of the systolic array, where lane i arrives i cycles after lane 0.
- It realigns all N lanes into whole row vectors, frames each burst with first/last markers, and buffers the rows in a small FIFO.
- The FIFO drains to the writeback/unified-buffer side under valid/ready backpressure.

Parameters:
- N, `ARRAY_SIZE, number of lanes (≥2).
- DATA_WIDTH, `DATA_WIDTH, bits per lane.
- FIFO_DEPTH, 4, aligned-row buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  advances deskew pipeline and framing FSM.
- data_in  in  [DATA_WIDTH-1:0] x N (unpacked)  skewed lanes from array edge.
- first_in  in  1  pulse, coincident with lane 0 of the burst's first row.
- last_in  in  1  pulse, coincident with lane N-1 of the burst's last row.
- data_out  out  [DATA_WIDTH-1:0] x N  aligned row at FIFO head.
- data_out_flat  out  N*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head row.
- out_first  out  1  head row is first of its burst.
- out_last  out  1  head row is last of its burst.
- busy  out  1  FSM in ACTIVE or FIFO non-empty.
- row_count  out  16  rows pushed in current/most recent burst.
- overflow  out  1  sticky: a row was dropped because the FIFO was full.
- proto_err  out  1  sticky: first seen while ACTIVE, or last seen while IDLE.
- clr_err  in  1  synchronous clear of overflow and proto_err.

Behaviour:
- Deskew stage: lane i passes through N-i register stages, gated by en. All lanes of one logical row emerge together N enabled cycles after lane 0 entered.
- Marker delays: first_in is delayed N stages; last_in is delayed 1 stage. Both are gated by en, giving aligned_first and aligned_last.
- With en=0 the deskew registers, marker pipelines and FSM hold their state. The FIFO still pops.
- FSM has two states, IDLE and ACTIVE. Each rule below applies on an enabled cycle:
  - IDLE with aligned_first: push row with first=1. If aligned_last is also set, mark last=1 (single-row burst) and stay IDLE; otherwise go to ACTIVE. Set row_count=1.
  - ACTIVE: push each aligned row and increment row_count (saturating at 0xFFFF). When aligned_last is set, mark last=1 and go to IDLE.
  - ACTIVE with aligned_first: set proto_err. Treat as a new burst start: push with first=1, row_count=1, stay ACTIVE unless aligned_last is also set.
  - IDLE with aligned_last only: set proto_err, no push.
  - IDLE with no markers: no push, regardless of data.
- FIFO entry holds the N lanes plus the first and last bits.
  - Show-ahead: data_out/out_first/out_last reflect the head entry whenever out_valid=1, and are don't-care otherwise.
  - Pop occurs when out_valid && out_ready.
  - Push while full with no same-cycle pop: row dropped, overflow set, row_count still increments.
  - Push while full with a same-cycle pop: accepted.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Latency: with en=1 and an empty FIFO, a row appears at out_valid N+1 cycles after its lane 0 entered (N deskew stages plus 1 FIFO write).
- clr_err clears both sticky flags in the same cycle. A same-cycle set wins over the clear.
- Reset values: all pipelines 0, FSM IDLE, FIFO empty, out_valid=0, out_first=0, out_last=0, busy=0, row_count=0, overflow=0, proto_err=0. data_out is 0 until the first write.
- Reset mid-burst discards all in-flight and buffered rows. No partial burst is emitted afterwards.

Test Plan:
1. N=4, FIFO_DEPTH=4, out_ready=1. Feed a 4-row skewed burst with row r lane i = 16*r+i, first_in at t0, last_in at t0+6. Required: rows {0,1,2,3}, {16..19}, {32..35}, {48..51} appear consecutively with out_valid first at t0+5, out_first on row 0, out_last on row 3, row_count=4.
2. Single-row burst: first_in at t0 and last_in at t0+3. Required: one row with out_first=out_last=1, FSM stays IDLE, proto_err=0.
3. Hold out_ready=0 during a 6-row burst with FIFO_DEPTH=4. Required: first 4 rows retained, rows 5–6 dropped, overflow=1, row_count=6. After out_ready=1, exactly 4 rows drain in order.
4. Deassert en for 3 cycles mid-burst, holding data_in. Required: output rows identical to the en=1 run, shifted by 3 cycles. FIFO drain continues during the stall.
5. first_in twice without last_in, then last_in with no open burst. Required: proto_err=1 after the second aligned first. clr_err clears it. An isolated last sets it again with no push.
6. Assert rst_n=0 after 2 rows are pushed and 1 row is still in flight. Required: all outputs return to reset values next cycle, and no stale row appears after release.

Source files
------------

// File: rtl/streaming_deskewer.sv
// Realigns the diagonally skewed result stream from the array edge into whole rows,
// frames bursts with first/last markers and buffers rows in a small show-ahead FIFO.
module streaming_deskewer #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [DATA_WIDTH-1:0]   data_in [N],
   input  logic                    first_in,
   input  logic                    last_in,
   output logic [DATA_WIDTH-1:0]   data_out [N],
   output logic [N*DATA_WIDTH-1:0] data_out_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    busy,
   output logic [15:0]             row_count,
   output logic                    overflow,
   output logic                    proto_err,
   input  logic                    clr_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [N*DATA_WIDTH-1:0] aligned_flat;
   logic [N-1:0]            first_pipe_q;
   logic                    last_q;
   logic                    aligned_first;
   logic                    aligned_last;

   // Lane gi gets N-gi stages so every lane of a row exits on the same cycle.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      localparam int STAGES = N - gi;
      logic [DATA_WIDTH-1:0] stage_q [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
         end else if (en) begin
            stage_q[0] <= data_in[gi];
            for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
         end
      end

      assign aligned_flat[gi*DATA_WIDTH +: DATA_WIDTH] = stage_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_pipe_q <= '0;
         last_q       <= 1'b0;
      end else if (en) begin
         first_pipe_q <= {first_pipe_q[N-2:0], first_in};
         last_q       <= last_in;
      end
   end

   assign aligned_first = first_pipe_q[N-1];
   assign aligned_last  = last_q;

   state_t      state_q, state_d;
   logic [15:0] row_count_q, row_count_d;
   logic        push, push_first, push_last, proto_set;

   always_comb begin
      state_d     = state_q;
      row_count_d = row_count_q;
      push        = 1'b0;
      push_first  = 1'b0;
      push_last   = 1'b0;
      proto_set   = 1'b0;
      if (en) begin
         if (aligned_first) begin
            // A first inside an open burst is flagged but still restarts framing.
            push        = 1'b1;
            push_first  = 1'b1;
            push_last   = aligned_last;
            row_count_d = 16'd1;
            proto_set   = (state_q == ACTIVE);
            state_d     = aligned_last ? IDLE : ACTIVE;
         end else if (state_q == ACTIVE) begin
            push        = 1'b1;
            push_last   = aligned_last;
            row_count_d = (row_count_q == 16'hFFFF) ? row_count_q : row_count_q + 16'd1;
            if (aligned_last) state_d = IDLE;
         end else if (aligned_last) begin
            proto_set = 1'b1;
         end
      end
   end

   logic [N*DATA_WIDTH-1:0] mem_row_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   mem_first_q;
   logic [FIFO_DEPTH-1:0]   mem_last_q;
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [AW:0]             count_q, count_d;
   logic                    full, pop, accept, drop;
   logic                    overflow_q, overflow_d;
   logic                    proto_err_q, proto_err_d;

   always_comb begin
      full   = (count_q == DEPTH_CNT);
      pop    = (count_q != '0) && out_ready;
      accept = push && (!full || pop);
      drop   = push && full && !pop;
      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A set on the same cycle as the clear takes priority.
      overflow_d  = clr_err ? 1'b0 : overflow_q;
      proto_err_d = clr_err ? 1'b0 : proto_err_q;
      if (drop)      overflow_d  = 1'b1;
      if (proto_set) proto_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_count_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_count_q <= row_count_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage is cleared on reset so the head reads zero until the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < FIFO_DEPTH; e++) mem_row_q[e] <= '0;
         mem_first_q <= '0;
         mem_last_q  <= '0;
      end else if (accept) begin
         mem_row_q[wr_ptr_q]   <= aligned_flat;
         mem_first_q[wr_ptr_q] <= push_first;
         mem_last_q[wr_ptr_q]  <= push_last;
      end
   end

   assign data_out_flat = mem_row_q[rd_ptr_q];
   assign out_first     = mem_first_q[rd_ptr_q];
   assign out_last      = mem_last_q[rd_ptr_q];
   assign out_valid     = (count_q != '0);
   assign busy          = (state_q == ACTIVE) || (count_q != '0);
   assign row_count     = row_count_q;
   assign overflow      = overflow_q;
   assign proto_err     = proto_err_q;

   for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign data_out[gi] = data_out_flat[gi*DATA_WIDTH +: DATA_WIDTH];
   end

endmodule

// File: tb/tb_streaming_deskewer.sv
// Bench for streaming_deskewer: directed bursts plus randomized traffic checked
// against a queue-based model built from enabled-cycle input histories.
module tb_streaming_deskewer;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int HMAX  = 4096;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [DW-1:0]     data_in [N];
   logic              first_in, last_in;
   logic [DW-1:0]     data_out [N];
   logic [N*DW-1:0]   data_out_flat;
   logic              out_valid, out_ready, out_first, out_last, busy;
   logic [15:0]       row_count;
   logic              overflow, proto_err, clr_err;

   streaming_deskewer #(.N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
      .first_in(first_in), .last_in(last_in),
      .data_out(data_out), .data_out_flat(data_out_flat),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last), .busy(busy),
      .row_count(row_count), .overflow(overflow), .proto_err(proto_err),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0][DW-1:0] d;
      logic                 f;
      logic                 l;
   } ent_t;

   ent_t            mq[$];
   logic [N*DW-1:0] cap[$];
   bit              m_open, m_ov, m_pe;
   int              m_rc, k, cyc, first_seen;
   int              ncmp, nerr;
   logic [DW-1:0]   hd [HMAX][N];
   bit              hf [HMAX];
   bit              hl [HMAX];
   logic [DW-1:0]   rowdata [8][N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_state();
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         for (int i = 0; i < N; i++) chk("data_out", data_out[i], mq[0].d[i]);
         chk("data_out_flat", data_out_flat, mq[0].d);
         chk("out_first", out_first, mq[0].f);
         chk("out_last", out_last, mq[0].l);
      end
      chk("row_count", row_count, m_rc);
      chk("overflow", overflow, m_ov);
      chk("proto_err", proto_err, m_pe);
      chk("busy", busy, m_open || (mq.size() != 0));
   endtask

   // One clock: advance the model from the current inputs, clock, then compare.
   task automatic tick();
      ent_t e;
      bit   af, al, push, pe_set, ov_set;
      push = 0; pe_set = 0; ov_set = 0; e = '0;
      if (out_valid && out_ready) cap.push_back(data_out_flat);
      if (en) begin
         af = (k >= N) ? hf[k-N] : 1'b0;
         al = (k >= 1) ? hl[k-1] : 1'b0;
         for (int i = 0; i < N; i++) e.d[i] = (k - N + i >= 0) ? hd[k-N+i][i] : '0;
         e.f = af;
         e.l = al;
         if (af) begin
            push = 1; pe_set = m_open; m_rc = 1; m_open = !al;
         end else if (m_open) begin
            push = 1; m_rc = (m_rc < 65535) ? m_rc + 1 : m_rc;
            if (al) m_open = 0;
         end else if (al) begin
            pe_set = 1;
         end
         for (int i = 0; i < N; i++) hd[k][i] = data_in[i];
         hf[k] = first_in;
         hl[k] = last_in;
         k++;
      end
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < DEPTH) mq.push_back(e);
         else ov_set = 1;
      end
      if (clr_err) begin m_ov = 0; m_pe = 0; end
      if (ov_set) m_ov = 1;
      if (pe_set) m_pe = 1;
      @(posedge clk);
      #1;
      cyc++;
      check_state();
      if (out_valid && first_seen < 0) first_seen = cyc;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) data_in[i] = DW'($urandom);
         first_in = 0; last_in = 0;
         tick();
      end
   endtask

   task automatic send_burst(input int R, input int stall_at, input int abort_at, input bit rnd);
      for (int c = 0; c < R + N - 1; c++) begin
         if (c == abort_at) return;
         for (int i = 0; i < N; i++)
            data_in[i] = (c - i >= 0 && c - i < R) ? rowdata[c-i][i] : DW'($urandom);
         first_in = (c == 0);
         last_in  = (c == R + N - 2);
         if (c == stall_at) begin
            en = 0;
            repeat (3) tick();
            en = 1;
         end
         if (rnd) begin
            do begin
               en = ($urandom_range(0, 7) != 0);
               out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end while (!en);
         end else begin
            tick();
         end
      end
      first_in = 0; last_in = 0; en = 1;
   endtask

   task automatic fill_rows(input bit counting);
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < N; i++)
            rowdata[r][i] = counting ? DW'(16*r + i) : DW'($urandom);
   endtask

   task automatic apply_reset();
      rst_n = 0;
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_first", out_first, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_row_count", row_count, 16'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_proto_err", proto_err, 1'b0);
      chk("rst_data_out", data_out_flat, '0);
      mq.delete();
      m_open = 0; m_rc = 0; m_ov = 0; m_pe = 0; k = 0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1;
   endtask

   initial begin
      int t0;
      ncmp = 0; nerr = 0; cyc = 0; k = 0; first_seen = -1;
      m_open = 0; m_rc = 0; m_ov = 0; m_pe = 0;
      rst_n = 0; en = 0; first_in = 0; last_in = 0; out_ready = 1; clr_err = 0;
      for (int i = 0; i < N; i++) data_in[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      apply_reset();
      en = 1;
      idle(3);

      // 1: four-row burst, counting data, check latency and row contents
      fill_rows(1);
      cap.delete();
      first_seen = -1;
      t0 = cyc;
      send_burst(4, -1, -1, 0);
      idle(4);
      chk("t1_latency", first_seen, t0 + N + 1);
      chk("t1_rows", cap.size(), 4);
      for (int r = 0; r < 4 && r < cap.size(); r++)
         for (int i = 0; i < N; i++)
            chk("t1_lane", cap[r][i*DW +: DW], 16*r + i);
      chk("t1_row_count", row_count, 16'd4);

      // 2: single-row burst
      fill_rows(0);
      cap.delete();
      send_burst(1, -1, -1, 0);
      idle(4);
      chk("t2_rows", cap.size(), 1);
      chk("t2_busy", busy, 1'b0);
      chk("t2_proto_err", proto_err, 1'b0);

      // 3: six rows into a four-deep FIFO with the consumer stalled
      fill_rows(0);
      out_ready = 0;
      send_burst(6, -1, -1, 0);
      idle(2);
      chk("t3_row_count", row_count, 16'd6);
      chk("t3_overflow", overflow, 1'b1);
      cap.delete();
      out_ready = 1;
      idle(6);
      chk("t3_drained", cap.size(), 4);
      for (int r = 0; r < 4 && r < cap.size(); r++)
         chk("t3_row", cap[r], {rowdata[r][3], rowdata[r][2], rowdata[r][1], rowdata[r][0]});
      clr_err = 1; idle(1); clr_err = 0;

      // 4: en stalls for three cycles mid-burst
      fill_rows(0);
      send_burst(4, 2, -1, 0);
      idle(4);
      out_ready = 0;
      send_burst(3, 3, -1, 0);
      out_ready = 1;
      idle(5);

      // 5: protocol errors
      first_in = 1; tick();
      first_in = 0; tick();
      first_in = 1; tick();
      first_in = 0;
      idle(N + 1);
      chk("t5_pe_set", proto_err, 1'b1);
      clr_err = 1; idle(1); clr_err = 0;
      chk("t5_pe_clr", proto_err, 1'b0);
      last_in = 1; tick(); last_in = 0;
      idle(4);
      chk("t5_close_ok", proto_err, 1'b0);
      cap.delete();
      last_in = 1; tick(); last_in = 0;
      idle(4);
      chk("t5_pe_isolated", proto_err, 1'b1);
      chk("t5_no_push", cap.size(), 0);
      clr_err = 1; idle(1); clr_err = 0;

      // 6: reset with two rows buffered and one in flight
      fill_rows(0);
      out_ready = 0;
      send_burst(4, -1, 6, 0);
      chk("t6_pre_valid", out_valid, 1'b1);
      apply_reset();
      en = 1; out_ready = 1;
      cap.delete();
      idle(10);
      chk("t6_no_stale", cap.size(), 0);

      // Randomized bursts with random en and backpressure
      for (int b = 0; b < 8; b++) begin
         fill_rows(0);
         send_burst($urandom_range(1, 6), -1, -1, 1);
         en = 1;
         for (int g = $urandom_range(0, 4); g > 0; g--) begin
            out_ready = ($urandom_range(0, 1) != 0);
            idle(1);
         end
         if ($urandom_range(0, 2) == 0) begin clr_err = 1; idle(1); clr_err = 0; end
      end
      out_ready = 1;
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
